mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_pkg.sv | 21 ++
 rtl/load_align.sv | 27 ++
 rtl/mem_access.sv | 141 ++++++++++++++
 tb/tb_mem_access.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the MEM-stage data-memory access unit:
// funct3 size codes, FSM state encoding and byte-enable patterns.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/load_align.sv
// Load formatter: picks the addressed byte/half out of a bus word and
// sign- or zero-extends it. Ports: rdata_i word, funct3_i size, off_i addr[1:0], data_o result.
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_w;
   logic [15:0] half_w;

   always_comb begin
      byte_w = rdata_i[{off_i, 3'b000} +: 8];
      half_w = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      unique case (1'b1)
         funct3_i == F3_B:  data_o = {{24{byte_w[7]}}, byte_w};
         funct3_i == F3_BU: data_o = {24'h0, byte_w};
         funct3_i == F3_H:  data_o = {{16{half_w[15]}}, half_w};
         funct3_i == F3_HU: data_o = {16'h0, half_w};
         default:           data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-memory access unit: IDLE/BUSY/DONE handshake with a stall to the pipeline.
// Ports: pipeline MEM_* in, dmem_* bus, MEM_Data_In load result, mem_stall, misalign (MISALIGN_CHECK_EN).
module mem_access
   import mem_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] MEM_Fout,
   input  logic [XLEN-1:0] MEM_Store,
   input  logic            MEM_MW,
   input  logic            MEM_MD,
   input  logic [2:0]      MEM_Funct3,
   input  logic            MEM_Valid,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic [XLEN-1:0] MEM_Data_In,
   output logic            mem_stall
`ifdef MISALIGN_CHECK_EN
   ,
   output logic            misalign
`endif
);

   state_e            state_q;
   logic              req_q;
   logic              we_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [3:0]        be_q;
   logic [XLEN-1:0]   data_q;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;

   logic              access;
   logic              mis;
   logic              start;
   logic [3:0]        be_d;
   logic [XLEN-1:0]   wdata_d;
   logic [XLEN-1:0]   ld_data;

   assign access = MEM_Valid & (MEM_MW | MEM_MD);

`ifdef MISALIGN_CHECK_EN
   logic mis_q;
   assign mis = ((MEM_Funct3[1:0] == F3_H[1:0]) && MEM_Fout[0])
              | ((MEM_Funct3[1:0] == F3_W[1:0]) && (MEM_Fout[1:0] != 2'b00));
   assign misalign = mis_q;
`else
   assign mis = 1'b0;
`endif

   assign start = (state_q == IDLE) & access & ~mis;

   // The IDLE cycle must already freeze the pipeline so the request
   // inputs stay put while the registered bus request is launched.
   assign mem_stall = rst_n & (start | (state_q == BUSY));

   always_comb begin
      be_d    = BE_W;
      wdata_d = MEM_Store;
      case (MEM_Funct3[1:0])
         F3_B[1:0]: begin
            be_d    = BE_B << MEM_Fout[1:0];
            wdata_d = {4{MEM_Store[7:0]}};
         end
         F3_H[1:0]: begin
            be_d    = BE_H << {MEM_Fout[1], 1'b0};
            wdata_d = {2{MEM_Store[15:0]}};
         end
         default: ;
      endcase
   end

   load_align u_load_align (
      .rdata_i  (dmem_rdata),
      .funct3_i (f3_q),
      .off_i    (off_q),
      .data_o   (ld_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         data_q  <= '0;
         f3_q    <= '0;
         off_q   <= '0;
`ifdef MISALIGN_CHECK_EN
         mis_q   <= 1'b0;
`endif
      end else begin
`ifdef MISALIGN_CHECK_EN
         mis_q <= (state_q == IDLE) & access & mis;
`endif
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= BUSY;
                  req_q   <= 1'b1;
                  // store wins when both MW and MD are set
                  we_q    <= MEM_MW;
                  addr_q  <= {MEM_Fout[XLEN-1:2], 2'b00};
                  be_q    <= be_d;
                  wdata_q <= MEM_MW ? wdata_d : '0;
                  f3_q    <= MEM_Funct3;
                  off_q   <= MEM_Fout[1:0];
               end
            end
            BUSY: begin
               if (dmem_ack) begin
                  state_q <= DONE;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  if (!we_q) data_q <= ld_data;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dmem_req    = req_q;
   assign dmem_we     = we_q;
   assign dmem_addr   = addr_q;
   assign dmem_wdata  = wdata_q;
   assign dmem_be     = be_q;
   assign MEM_Data_In = data_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, wait states, bubbles,
// stray acks, reset mid-access and (with MISALIGN_CHECK_EN) misalignment.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] MEM_Fout = '0;
   logic [31:0] MEM_Store = '0;
   logic        MEM_MW = 1'b0;
   logic        MEM_MD = 1'b0;
   logic [2:0]  MEM_Funct3 = '0;
   logic        MEM_Valid = 1'b0;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic [31:0] MEM_Data_In;
   logic        mem_stall;
`ifdef MISALIGN_CHECK_EN
   logic        misalign;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_access #(.XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .MEM_Fout    (MEM_Fout),
      .MEM_Store   (MEM_Store),
      .MEM_MW      (MEM_MW),
      .MEM_MD      (MEM_MD),
      .MEM_Funct3  (MEM_Funct3),
      .MEM_Valid   (MEM_Valid),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_be     (dmem_be),
      .dmem_ack    (dmem_ack),
      .dmem_rdata  (dmem_rdata),
      .MEM_Data_In (MEM_Data_In),
      .mem_stall   (mem_stall)
`ifdef MISALIGN_CHECK_EN
      ,
      .misalign    (misalign)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drives one MEM-stage access and plays the bus: ack in the
   // ack_at-th BUSY cycle. Returns at posedge+1 after the DONE edge.
   task automatic acc(
      input  logic        mw,
      input  logic        md,
      input  logic [2:0]  f3,
      input  logic [31:0] a,
      input  logic [31:0] st,
      input  logic [31:0] rd,
      input  int          ack_at,
      output int          stalls,
      output int          busy,
      output logic [3:0]  be,
      output logic [31:0] wd,
      output logic [31:0] ad,
      output logic        we
   );
      logic done;
      MEM_Valid  = 1'b1;
      MEM_MW     = mw;
      MEM_MD     = md;
      MEM_Funct3 = f3;
      MEM_Fout   = a;
      MEM_Store  = st;
      stalls = 0;
      busy   = 0;
      be = '0; wd = '0; ad = '0; we = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 32 && !done; c++) begin
         #1;
         if (dmem_req) begin
            busy++;
            be = dmem_be;
            wd = dmem_wdata;
            ad = dmem_addr;
            we = dmem_we;
         end
         dmem_ack   = dmem_req && (busy == ack_at);
         dmem_rdata = dmem_ack ? rd : 32'h0;
         if (mem_stall) stalls++;
         else done = 1'b1;
         @(posedge clk);
      end
      #1;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      chk("no_timeout", {31'h0, done}, 32'h1);
   endtask

   task automatic idle_cycle();
      MEM_Valid = 1'b0;
      MEM_MW    = 1'b0;
      MEM_MD    = 1'b0;
      @(posedge clk);
      #1;
   endtask

   int          st_n, bz_n;
   logic [3:0]  be_s;
   logic [31:0] wd_s, ad_s;
   logic        we_s;
   logic [31:0] last;

   initial begin
      #12;
      chk("rst_req",   {31'h0, dmem_req},  32'h0);
      chk("rst_we",    {31'h0, dmem_we},   32'h0);
      chk("rst_be",    {28'h0, dmem_be},   32'h0);
      chk("rst_addr",  dmem_addr,          32'h0);
      chk("rst_wdata", dmem_wdata,         32'h0);
      chk("rst_data",  MEM_Data_In,        32'h0);
      chk("rst_stall", {31'h0, mem_stall}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_cycle();

      // LW zero-wait
      acc(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1,
          st_n, bz_n, be_s, wd_s, ad_s, we_s);
      chk("lw_stalls", st_n, 2);
      chk("lw_addr",   ad_s, 32'h100);
      chk("lw_we",     {31'h0, we_s}, 32'h0);
      chk("lw_data",   MEM_Data_In, 32'hDEADBEEF);

      // back-to-back loads, byte/half extraction
      acc(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 32'h80112233, 1,
          st_n, bz_n, be_s, wd_s, ad_s, we_s);
      chk("lb_stalls", st_n, 2);
      chk("lb_data",   MEM_Data_In, 32'hFFFFFF80);
      acc(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 32'h80112233, 1,
          st_n, bz_n, be_s, wd_s, ad_s, we_s);
      chk("lbu_data",  MEM_Data_In, 32'h00000080);
      acc(1'b0, 1'b1, 3'b101, 32'h102, 32'h0, 32'h80112233, 1,
          st_n, bz_n, be_s, wd_s, ad_s, we_s);
      chk("lhu_data",  MEM_Data_In, 32'h00008011);
      acc(1'b0, 1'b1, 3'b001, 32'h102, 32'h0, 32'h80112233, 1,
          st_n, bz_n, be_s, wd_s, ad_s, we_s);
      chk("lh_data",   MEM_Data_In, 32'hFFFF8011);
      acc(1'b0, 1'b1, 3'b001, 32'h100, 32'h0, 32'h80112233, 1,
          st_n, bz_n, be_s, wd_s, ad_s, we_s);
      chk("lh0_data",  MEM_Data_In, 32'h00002233);
      acc(1'b0, 1'b1, 3'b000, 32'h101, 32'h0, 32'h80112233, 1,
          st_n, bz_n, be_s, wd_s, ad_s, we_s);
      chk("lb1_data",  MEM_Data_In, 32'h00000022);
      last = 32'h00000022;

      // stores leave MEM_Data_In alone
      acc(1'b1, 1'b0, 3'b000, 32'h201, 32'h000000AB, 32'h0, 1,
          st_n, bz_n, be_s, wd_s, ad_s, we_s);
      chk("sb_be",     {28'h0, be_s}, 32'h2);
      chk("sb_wdata",  wd_s, 32'hABABABAB);
      chk("sb_we",     {31'h0, we_s}, 32'h1);
      chk("sb_addr",   ad_s, 32'h200);
      chk("sb_data",   MEM_Data_In, last);
      acc(1'b1, 1'b0, 3'b001, 32'h202, 32'h1234CDEF, 32'h0, 1,
          st_n, bz_n, be_s, wd_s, ad_s, we_s);
      chk("sh_be",     {28'h0, be_s}, 32'hC);
      chk("sh_wdata",  wd_s, 32'hCDEFCDEF);
      acc(1'b1, 1'b0, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 1,
          st_n, bz_n, be_s, wd_s, ad_s, we_s);
      chk("sw_be",     {28'h0, be_s}, 32'hF);
      chk("sw_wdata",  wd_s, 32'hCAFEF00D);

      // MW and MD together: store wins, load data ignored
      acc(1'b1, 1'b1, 3'b010, 32'h208, 32'h01020304, 32'h77777777, 1,
          st_n, bz_n, be_s, wd_s, ad_s, we_s);
      chk("both_we",   {31'h0, we_s}, 32'h1);
      chk("both_data", MEM_Data_In, last);

      // ack in the 3rd BUSY cycle
      acc(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 32'h13572468, 3,
          st_n, bz_n, be_s, wd_s, ad_s, we_s);
      chk("wait_stalls", st_n, 4);
      chk("wait_busy",   bz_n, 3);
      chk("wait_data",   MEM_Data_In, 32'h13572468);
      last = 32'h13572468;

      // bubble with MW set
      MEM_Valid = 1'b0; MEM_MW = 1'b1; MEM_MD = 1'b0;
      #1;
      chk("bub_stall", {31'h0, mem_stall}, 32'h0);
      @(posedge clk);
      #1;
      chk("bub_req",   {31'h0, dmem_req}, 32'h0);

      // stray ack in IDLE
      MEM_MW = 1'b0;
      dmem_ack = 1'b1; dmem_rdata = 32'h99999999;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0; dmem_rdata = '0;
      chk("stray_data", MEM_Data_In, last);
      chk("stray_req",  {31'h0, dmem_req}, 32'h0);

`ifdef MISALIGN_CHECK_EN
      acc(1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 32'h0, 1,
          st_n, bz_n, be_s, wd_s, ad_s, we_s);
      chk("mis_stall", st_n, 0);
      chk("mis_flag",  {31'h0, misalign}, 32'h1);
      chk("mis_req",   {31'h0, dmem_req}, 32'h0);
      idle_cycle();
      chk("mis_pulse", {31'h0, misalign}, 32'h0);
      chk("mis_data",  MEM_Data_In, last);
      acc(1'b1, 1'b0, 3'b001, 32'h201, 32'h1111, 32'h0, 1,
          st_n, bz_n, be_s, wd_s, ad_s, we_s);
      chk("missh_flag", {31'h0, misalign}, 32'h1);
      chk("missh_req",  {31'h0, dmem_req}, 32'h0);
      idle_cycle();
`else
      // without the check, word access ignores addr[1:0]
      acc(1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 32'h12345678, 1,
          st_n, bz_n, be_s, wd_s, ad_s, we_s);
      chk("lwu_stalls", st_n, 2);
      chk("lwu_addr",   ad_s, 32'h100);
      chk("lwu_data",   MEM_Data_In, 32'h12345678);
      idle_cycle();
`endif

      // reset while BUSY, then a late ack
      MEM_Valid = 1'b1; MEM_MD = 1'b1; MEM_MW = 1'b0;
      MEM_Funct3 = 3'b010; MEM_Fout = 32'h400;
      @(posedge clk);
      #1;
      chk("rb_req_on", {31'h0, dmem_req}, 32'h1);
      #2;
      rst_n = 1'b0;
      MEM_Valid = 1'b0; MEM_MD = 1'b0;
      #1;
      chk("rb_req_off", {31'h0, dmem_req}, 32'h0);
      chk("rb_stall",   {31'h0, mem_stall}, 32'h0);
      chk("rb_data",    MEM_Data_In, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      dmem_ack = 1'b1; dmem_rdata = 32'h55555555;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0; dmem_rdata = '0;
      chk("late_data",  MEM_Data_In, 32'h0);
      chk("late_req",   {31'h0, dmem_req}, 32'h0);
      chk("late_stall", {31'h0, mem_stall}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
